// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - pipeline/long-latency/regfile signal bundle for wb_port_arbiter
interface wb_port_arbiter_if #(
    parameter int XLEN = 64
);
    logic            pipe_wreg_i;
    logic [4:0]      pipe_rd_addr_i;
    logic [XLEN-1:0] pipe_wdata_i;
    logic            ll_valid_i;
    logic            ll_ready_o;
    logic [4:0]      ll_rd_addr_i;
    logic [XLEN-1:0] ll_wdata_i;
    logic            rf_we_o;
    logic [4:0]      rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;
    logic            wb_back_wreg_o;
    logic [4:0]      wb_back_rd_addr_o;
    logic [XLEN-1:0] wb_back_wdata_o;
    logic            stall_req_o;
    logic [31:0]     stat_conflict_o;
    logic [31:0]     stat_drain_o;

    modport slave (
        input  pipe_wreg_i, pipe_rd_addr_i, pipe_wdata_i,
        input  ll_valid_i, ll_rd_addr_i, ll_wdata_i,
        output ll_ready_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o,
        output wb_back_wreg_o, wb_back_rd_addr_o, wb_back_wdata_o,
        output stall_req_o, stat_conflict_o, stat_drain_o
    );

    modport master (
        output pipe_wreg_i, pipe_rd_addr_i, pipe_wdata_i,
        output ll_valid_i, ll_rd_addr_i, ll_wdata_i,
        input  ll_ready_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o,
        input  wb_back_wreg_o, wb_back_rd_addr_o, wb_back_wdata_o,
        input  stall_req_o, stat_conflict_o, stat_drain_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - regfile write-port arbiter between pipeline writeback and buffered long-latency results
// Define WB_ARB_STATS_EN to enable the conflict/drain statistics counters.
module wb_port_arbiter #(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    typedef enum logic {S_NORMAL, S_DRAIN} state_e;

    state_e          state_q, state_d;
    logic [3:0]      starve_q, starve_d;
    logic [FIFO_DEPTH-1:0] vld_q, vld_d;
    logic [4:0]      rd_q  [FIFO_DEPTH];
    logic [4:0]      rd_d  [FIFO_DEPTH];
    logic [XLEN-1:0] dat_q [FIFO_DEPTH];
    logic [XLEN-1:0] dat_d [FIFO_DEPTH];
    logic [CW-1:0]   n;

    logic pipe_req, full, nonempty, ll_ready, push, enq;
    logic grant_pipe, pop, conflict;
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;

    assign pipe_req   = bus.pipe_wreg_i && (bus.pipe_rd_addr_i != 5'd0);
    assign full       = &vld_q;
    assign nonempty   = vld_q[0];
    assign ll_ready   = !rst && !full && (state_q == S_NORMAL);
    assign push       = bus.ll_valid_i && ll_ready;
    assign enq        = push && (bus.ll_rd_addr_i != 5'd0);
    assign grant_pipe = (state_q == S_NORMAL) && pipe_req;
    assign pop        = !grant_pipe && nonempty;
    assign conflict   = grant_pipe && nonempty;

    // Entries are kept packed at the low slots; kills and pops re-compact them
    always_comb begin
        vld_d = '0;
        rd_d  = rd_q;
        dat_d = dat_q;
        n     = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (vld_q[i] && !(grant_pipe && rd_q[i] == bus.pipe_rd_addr_i) && !(i == 0 && pop)) begin
                vld_d[n[AW-1:0]] = 1'b1;
                rd_d[n[AW-1:0]]  = rd_q[i];
                dat_d[n[AW-1:0]] = dat_q[i];
                n = n + CW'(1);
            end
        end
        if (enq) begin
            vld_d[n[AW-1:0]] = 1'b1;
            rd_d[n[AW-1:0]]  = bus.ll_rd_addr_i;
            dat_d[n[AW-1:0]] = bus.ll_wdata_i;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (pop || vld_d == '0)
            starve_d = 4'd0;
        else if (conflict && starve_q != 4'hF)
            starve_d = starve_q + 4'd1;
        state_d = state_q;
        case (state_q)
            S_NORMAL: if (conflict && starve_d == SMAX) state_d = S_DRAIN;
            S_DRAIN:  if (vld_d == '0) state_d = S_NORMAL;
            default:  state_d = S_NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_NORMAL;
            starve_q <= 4'd0;
            vld_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rd_q[i]  <= 5'd0;
                dat_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            vld_q    <= vld_d;
            rd_q     <= rd_d;
            dat_q    <= dat_d;
        end
    end

    always_comb begin
        we    = 1'b0;
        waddr = 5'd0;
        wdata = '0;
        if (!rst && grant_pipe) begin
            we    = 1'b1;
            waddr = bus.pipe_rd_addr_i;
            wdata = bus.pipe_wdata_i;
        end else if (!rst && pop) begin
            we    = 1'b1;
            waddr = rd_q[0];
            wdata = dat_q[0];
        end
    end

    assign bus.ll_ready_o        = ll_ready;
    assign bus.rf_we_o           = we;
    assign bus.rf_waddr_o        = waddr;
    assign bus.rf_wdata_o        = wdata;
    assign bus.wb_back_wreg_o    = we;
    assign bus.wb_back_rd_addr_o = waddr;
    assign bus.wb_back_wdata_o   = wdata;
    assign bus.stall_req_o       = (state_q == S_DRAIN);

`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_conf_q, stat_drain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_conf_q  <= 32'd0;
            stat_drain_q <= 32'd0;
        end else begin
            if (conflict)           stat_conf_q  <= stat_conf_q + 32'd1;
            if (state_q == S_DRAIN) stat_drain_q <= stat_drain_q + 32'd1;
        end
    end

    assign bus.stat_conflict_o = stat_conf_q;
    assign bus.stat_drain_o    = stat_drain_q;
`else
    assign bus.stat_conflict_o = 32'd0;
    assign bus.stat_drain_o    = 32'd0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed and randomized bench for wb_port_arbiter against a queue-based model
module tb_wb_port_arbiter;
    localparam int XLEN  = 64;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ent_t        q[$];
    bit          m_drain;
    int          m_starve;
    int unsigned m_conf;
    int unsigned m_dr;

    wb_port_arbiter_if #(.XLEN(XLEN)) bus ();

    wb_port_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_drain  = 0;
        m_starve = 0;
        m_conf   = 0;
        m_dr     = 0;
    endtask

    task automatic check_stats();
`ifdef WB_ARB_STATS_EN
        chk("stat_conflict", bus.stat_conflict_o, 64'(m_conf));
        chk("stat_drain", bus.stat_drain_o, 64'(m_dr));
`else
        chk("stat_conflict", bus.stat_conflict_o, 64'd0);
        chk("stat_drain", bus.stat_drain_o, 64'd0);
`endif
    endtask

    task automatic step(input bit w, input logic [4:0] prd, input logic [63:0] pd,
                        input bit lv, input logic [4:0] lrd, input logic [63:0] ld);
        bit          preq, ready, gp, pop, conflict;
        logic        e_we;
        logic [4:0]  e_a;
        logic [63:0] e_d;
        ent_t        nq[$];
        @(negedge clk);
        bus.pipe_wreg_i    = w;
        bus.pipe_rd_addr_i = prd;
        bus.pipe_wdata_i   = pd;
        bus.ll_valid_i     = lv;
        bus.ll_rd_addr_i   = lrd;
        bus.ll_wdata_i     = ld;
        #1;
        preq  = w && (prd != 5'd0);
        ready = (q.size() < DEPTH) && !m_drain;
        gp    = !m_drain && preq;
        pop   = !gp && (q.size() > 0);
        e_we  = gp || pop;
        e_a   = gp ? prd : (pop ? q[0].rd : 5'd0);
        e_d   = gp ? pd  : (pop ? q[0].d  : 64'd0);
        chk("rf_we", bus.rf_we_o, e_we);
        chk("rf_waddr", bus.rf_waddr_o, e_a);
        chk("rf_wdata", bus.rf_wdata_o, e_d);
        chk("wb_back_wreg", bus.wb_back_wreg_o, e_we);
        chk("wb_back_rd", bus.wb_back_rd_addr_o, e_a);
        chk("wb_back_wdata", bus.wb_back_wdata_o, e_d);
        chk("ll_ready", bus.ll_ready_o, ready);
        chk("stall_req", bus.stall_req_o, m_drain);
        check_stats();
        conflict = gp && (q.size() > 0);
        if (gp) begin
            foreach (q[k]) if (q[k].rd != prd) nq.push_back(q[k]);
            q = nq;
        end
        if (pop) void'(q.pop_front());
        if (lv && ready && lrd != 5'd0) q.push_back('{lrd, ld});
        if (conflict) m_conf++;
        if (m_drain) m_dr++;
        if (pop || q.size() == 0) m_starve = 0;
        else if (conflict && m_starve < 15) m_starve++;
        if (m_drain) m_drain = (q.size() != 0);
        else         m_drain = conflict && (m_starve == SMAX);
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.pipe_wreg_i    = 1'b1;
        bus.pipe_rd_addr_i = 5'd5;
        bus.pipe_wdata_i   = 64'h55;
        bus.ll_valid_i     = 1'b1;
        bus.ll_rd_addr_i   = 5'd3;
        bus.ll_wdata_i     = 64'h33;
        model_reset();
        #12;
        chk("rst_rf_we", bus.rf_we_o, 64'd0);
        chk("rst_rf_waddr", bus.rf_waddr_o, 64'd0);
        chk("rst_rf_wdata", bus.rf_wdata_o, 64'd0);
        chk("rst_ll_ready", bus.ll_ready_o, 64'd0);
        chk("rst_stall", bus.stall_req_o, 64'd0);
        check_stats();
        @(negedge clk);
        rst = 1'b0;
        bus.pipe_wreg_i = 1'b0;
        bus.ll_valid_i  = 1'b0;

        // pipe-only, including rd 0
        step(1, 5'd5, 64'h1234, 0, 5'd0, 64'd0);
        step(1, 5'd0, 64'h9999, 0, 5'd0, 64'd0);
        // long-latency only
        step(0, 5'd0, 64'd0, 1, 5'd7, 64'hAA);
        step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        // starvation into a forced drain
        step(0, 5'd0, 64'd0, 1, 5'd7, 64'h77);
        for (int r = 1; r <= 4; r++) step(1, 5'(r), 64'(r), 0, 5'd0, 64'd0);
        step(1, 5'd4, 64'd4, 0, 5'd0, 64'd0);
        step(1, 5'd4, 64'd4, 0, 5'd0, 64'd0);
        step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        // fill to full while the pipe writes every cycle
        step(1, 5'd1, 64'h10, 1, 5'd8, 64'h80);
        step(1, 5'd2, 64'h20, 1, 5'd9, 64'h90);
        for (int r = 0; r < 6; r++) step(1, 5'(3 + r), 64'(r), 1, 5'd10, 64'hA0);
        step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        // WAW kill of a buffered result
        step(1, 5'd3, 64'h3, 1, 5'd9, 64'h1);
        step(1, 5'd9, 64'h2, 0, 5'd0, 64'd0);
        step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        // push and kill of the same rd in one cycle keeps the new push
        step(1, 5'd3, 64'h3, 1, 5'd9, 64'h1);
        step(1, 5'd9, 64'h2, 1, 5'd9, 64'h5);
        step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        // reset in the middle of a two-entry drain
        step(1, 5'd1, 64'h1, 1, 5'd10, 64'hA);
        step(1, 5'd2, 64'h2, 1, 5'd11, 64'hB);
        for (int r = 3; r <= 5; r++) step(1, 5'(r), 64'(r), 0, 5'd0, 64'd0);
        step(1, 5'd5, 64'd5, 0, 5'd0, 64'd0);
        @(negedge clk);
        chk("drain_stall_before_rst", bus.stall_req_o, 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_stall", bus.stall_req_o, 64'd0);
        chk("midrst_rf_we", bus.rf_we_o, 64'd0);
        chk("midrst_ll_ready", bus.ll_ready_o, 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
        step(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);

        for (int c = 0; c < 800; c++)
            step(($urandom % 4) != 0, 5'($urandom % 6), {$urandom, $urandom},
                 ($urandom % 2) == 1, 5'($urandom % 6), {$urandom, $urandom});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
